// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module  : pipe_stage_reg
// Brief   : Valid/allowin pipeline stage latch with stall and flush. Define
//           PIPE_SKID_EN for the 2-entry skid buffer with flop-only in_allowin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W     = 192,
    parameter int FLUSH_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic              push;
    logic              pop;
    logic              h_v_q;
    logic              h_v_d;
    logic [DATA_W-1:0] h_data_q;
    logic [DATA_W-1:0] h_data_d;

    assign out_valid = h_v_q & ~stall;
    assign pop       = out_valid & out_allowin;
    assign push      = in_valid & in_allowin & ~flush;
    assign out_data  = h_data_q;

`ifdef PIPE_SKID_EN
    logic              s_v_q;
    logic              s_v_d;
    logic [DATA_W-1:0] s_data_q;
    logic [DATA_W-1:0] s_data_d;

    // Only a free skid slot matters, so the downstream allowin never reaches upstream.
    assign in_allowin = ~s_v_q;
    assign occ        = {1'b0, h_v_q} + {1'b0, s_v_q};

    always_comb begin
        h_v_d    = h_v_q;
        h_data_d = h_data_q;
        s_v_d    = s_v_q;
        s_data_d = s_data_q;
        if (flush) begin
            h_v_d = 1'b0;
            s_v_d = 1'b0;
            if (FLUSH_ZERO != 0) begin
                h_data_d = '0;
                s_data_d = '0;
            end
        end else if (s_v_q) begin
            if (pop) begin
                h_data_d = s_data_q;
                s_v_d    = 1'b0;
            end
        end else if (h_v_q) begin
            if (push && pop) begin
                h_data_d = in_data;
            end else if (push) begin
                s_v_d    = 1'b1;
                s_data_d = in_data;
            end else if (pop) begin
                h_v_d = 1'b0;
            end
        end else if (push) begin
            h_v_d    = 1'b1;
            h_data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_v_q <= 1'b0;
            if (FLUSH_ZERO != 0) begin
                s_data_q <= '0;
            end
        end else begin
            s_v_q    <= s_v_d;
            s_data_q <= s_data_d;
        end
    end
`else
    assign in_allowin = ~h_v_q | (~stall & out_allowin);
    assign occ        = {1'b0, h_v_q};

    always_comb begin
        h_v_d    = h_v_q;
        h_data_d = h_data_q;
        if (flush) begin
            h_v_d = 1'b0;
            if (FLUSH_ZERO != 0) begin
                h_data_d = '0;
            end
        end else if (push) begin
            h_v_d    = 1'b1;
            h_data_d = in_data;
        end else if (pop) begin
            h_v_d = 1'b0;
        end
    end
`endif

    // With FLUSH_ZERO=0 the payload flops carry no reset at all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_v_q <= 1'b0;
            if (FLUSH_ZERO != 0) begin
                h_data_q <= '0;
            end
        end else begin
            h_v_q    <= h_v_d;
            h_data_q <= h_data_d;
        end
    end

endmodule

`default_nettype wire
